// File: rtl/ext_pkg.sv
// Shared opcodes, extension modes and skid-buffer states for the immediate/load extender.
package ext_pkg;

  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_LBU  = 6'b100100;
  localparam logic [5:0] OP_LH   = 6'b100001;
  localparam logic [5:0] OP_LHU  = 6'b100101;
  localparam logic [5:0] OP_LW   = 6'b100011;

  typedef enum logic [2:0] {
    SIGN, ZERO, UPPER, LDB_S, LDB_U, LDH_S, LDH_U, LDW
  } ext_mode_t;

  typedef enum logic [1:0] {
    EMPTY, ONE, TWO
  } buf_state_t;

endpackage

// File: rtl/ext_core.sv
// Combinational opcode decode, lane select and extension, plus the halfword misalign flag.
module ext_core
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int OP_W   = 6,
  parameter int BOFF_W = $clog2(DATA_W/8)
) (
  input  logic [OP_W-1:0]   op_i,
  input  logic [IMM_W-1:0]  imm_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic [BOFF_W-1:0] boff_i,
  output logic [DATA_W-1:0] data_o,
  output logic              misalign_o
);

  ext_mode_t         mode;
  logic [DATA_W-1:0] byte_sh;
  logic [DATA_W-1:0] half_sh;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;

  always_comb begin
    unique case (op_i)
      OP_ANDI, OP_ORI, OP_XORI: mode = ZERO;
      OP_LUI:                   mode = UPPER;
      OP_LB:                    mode = LDB_S;
      OP_LBU:                   mode = LDB_U;
      OP_LH:                    mode = LDH_S;
      OP_LHU:                   mode = LDH_U;
      OP_LW:                    mode = LDW;
      default:                  mode = SIGN;
    endcase
  end

  // Little-endian lanes: shift the selected byte/halfword down to bit 0.
  assign byte_sh = word_i >> {boff_i, 3'b000};
  assign half_sh = word_i >> {boff_i[BOFF_W-1:1], 4'b0000};
  assign lane_b  = byte_sh[7:0];
  assign lane_h  = half_sh[15:0];

  always_comb begin
    data_o     = '0;
    misalign_o = 1'b0;
    unique case (mode)
      ZERO:  data_o = {{(DATA_W-IMM_W){1'b0}}, imm_i};
      UPPER: data_o[2*IMM_W-1:IMM_W] = imm_i;
      LDB_S: data_o = {{(DATA_W-8){lane_b[7]}}, lane_b};
      LDB_U: data_o = {{(DATA_W-8){1'b0}}, lane_b};
      LDH_S, LDH_U: begin
        if (boff_i[0]) begin
          misalign_o = 1'b1;
        end else if (mode == LDH_S) begin
          data_o = {{(DATA_W-16){lane_h[15]}}, lane_h};
        end else begin
          data_o = {{(DATA_W-16){1'b0}}, lane_h};
        end
      end
      LDW:     data_o = word_i;
      default: data_o = {{(DATA_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};
    endcase
  end

endmodule

// File: rtl/ext_unit_pipe.sv
// Registered extender with a 2-entry skid buffer; in_ready comes straight from a flop.
//   state | meaning
//   EMPTY | no item held, out_valid=0
//   ONE   | main register holds the head item
//   TWO   | main holds head, skid holds the next item, in_ready=0
module ext_unit_pipe
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int OP_W   = 6,
  parameter int BOFF_W = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [DATA_W-1:0] in_word,
  input  logic [BOFF_W-1:0] in_boff,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_misalign
);

  buf_state_t        state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic              main_mis_q, main_mis_d, skid_mis_q, skid_mis_d;
  logic              in_ready_q, in_ready_d;
  logic [DATA_W-1:0] ext_data;
  logic              ext_mis;
  logic              in_fire, out_fire;

  ext_core #(
    .DATA_W(DATA_W), .IMM_W(IMM_W), .OP_W(OP_W), .BOFF_W(BOFF_W)
  ) u_core (
    .op_i(in_op), .imm_i(in_imm), .word_i(in_word), .boff_i(in_boff),
    .data_o(ext_data), .misalign_o(ext_mis)
  );

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_mis_d  = main_mis_q;
    skid_data_d = skid_data_q;
    skid_mis_d  = skid_mis_q;
    unique case (state_q)
      EMPTY: if (in_fire) begin
        main_data_d = ext_data;
        main_mis_d  = ext_mis;
        state_d     = ONE;
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_data_d = ext_data;
          main_mis_d  = ext_mis;
        end else if (in_fire) begin
          skid_data_d = ext_data;
          skid_mis_d  = ext_mis;
          state_d     = TWO;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: if (out_fire) begin
        main_data_d = skid_data_q;
        main_mis_d  = skid_mis_q;
        state_d     = ONE;
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_mis_q  <= 1'b0;
      skid_data_q <= '0;
      skid_mis_q  <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_mis_q  <= main_mis_d;
      skid_data_q <= skid_data_d;
      skid_mis_q  <= skid_mis_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = (state_q != EMPTY);
  assign out_data     = main_data_q;
  assign out_misalign = main_mis_q;

endmodule

// File: tb/tb_ext_unit_pipe.sv
// Directed bench for ext_unit_pipe: inputs driven and outputs sampled on the falling edge.
module tb_ext_unit_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [15:0] in_imm;
  logic [31:0] in_word;
  logic [1:0]  in_boff;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_misalign;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ext_unit_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_imm(in_imm), .in_word(in_word), .in_boff(in_boff),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_misalign(out_misalign)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [15:0] imm,
                       input logic [31:0] word, input logic [1:0] boff);
    in_valid = 1'b1;
    in_op    = op;
    in_imm   = imm;
    in_word  = word;
    in_boff  = boff;
  endtask

  typedef struct {
    string       tag;
    logic [5:0]  op;
    logic [15:0] imm;
    logic [31:0] word;
    logic [1:0]  boff;
    logic [31:0] exp_data;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"addi",    6'b001000, 16'h8001, 32'h0,        2'd0, 32'hFFFF8001, 1'b0});
    vecs.push_back('{"ori",     6'b001101, 16'h8001, 32'h0,        2'd0, 32'h00008001, 1'b0});
    vecs.push_back('{"lui",     6'b001111, 16'h1234, 32'h0,        2'd0, 32'h12340000, 1'b0});
    vecs.push_back('{"andi",    6'b001100, 16'hFFFF, 32'hDEADBEEF, 2'd3, 32'h0000FFFF, 1'b0});
    vecs.push_back('{"lb_b2",   6'b100000, 16'h0,    32'h80FF7F01, 2'd2, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{"lb_b1",   6'b100000, 16'h0,    32'h80FF7F01, 2'd1, 32'h0000007F, 1'b0});
    vecs.push_back('{"lbu_b3",  6'b100100, 16'h0,    32'h80FF7F01, 2'd3, 32'h00000080, 1'b0});
    vecs.push_back('{"lh_b2",   6'b100001, 16'h0,    32'h80FF7F01, 2'd2, 32'hFFFF80FF, 1'b0});
    vecs.push_back('{"lhu_b0",  6'b100101, 16'h0,    32'h80FF7F01, 2'd0, 32'h00007F01, 1'b0});
    vecs.push_back('{"lw",      6'b100011, 16'h0,    32'h80FF7F01, 2'd1, 32'h80FF7F01, 1'b0});
    vecs.push_back('{"lh_mis",  6'b100001, 16'h0,    32'h80FF7F01, 2'd1, 32'h00000000, 1'b1});
    vecs.push_back('{"lhu_b2",  6'b100101, 16'h0,    32'h80FF7F01, 2'd2, 32'h000080FF, 1'b0});

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_imm = '0; in_word = '0; in_boff = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("rst_out_data",  out_data,           32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_out_valid", {31'b0, out_valid}, 32'd0);
    check("rel_in_ready",  {31'b0, in_ready},  32'd1);
    check("rel_mis",       {31'b0, out_misalign}, 32'd0);

    // back-to-back stream with out_ready high: each result one cycle after accept
    out_ready = 1'b1;
    for (int i = 0; i <= vecs.size(); i++) begin
      if (i > 0) begin
        check({vecs[i-1].tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({vecs[i-1].tag, "_data"},  out_data, vecs[i-1].exp_data);
        check({vecs[i-1].tag, "_mis"},   {31'b0, out_misalign}, {31'b0, vecs[i-1].exp_mis});
      end
      if (i < vecs.size()) begin
        check("stream_in_ready", {31'b0, in_ready}, 32'd1);
        drive(vecs[i].op, vecs[i].imm, vecs[i].word, vecs[i].boff);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("drain_valid", {31'b0, out_valid}, 32'd0);

    // stall: A, B fill the buffer, C waits
    out_ready = 1'b0;
    drive(6'b001000, 16'h000A, 32'h0, 2'd0);
    check("st_rdy0", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    check("st_A_held1", out_data, 32'h0000000A);
    check("st_rdy1", {31'b0, in_ready}, 32'd1);
    drive(6'b001101, 16'h000B, 32'h0, 2'd0);
    @(negedge clk);
    check("st_rdy2", {31'b0, in_ready}, 32'd0);
    check("st_A_held2", out_data, 32'h0000000A);
    drive(6'b001111, 16'h000C, 32'h0, 2'd0);
    @(negedge clk);
    check("st_rdy3", {31'b0, in_ready}, 32'd0);
    check("st_A_held3", out_data, 32'h0000000A);
    check("st_A_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("st_B", out_data, 32'h0000000B);
    check("st_rdy_back", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    check("st_C", out_data, 32'h000C0000);
    check("st_C_valid", {31'b0, out_valid}, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    check("st_drain", {31'b0, out_valid}, 32'd0);

    // reset asserted while holding two items
    out_ready = 1'b0;
    drive(6'b001000, 16'h0001, 32'h0, 2'd0);
    @(negedge clk);
    drive(6'b001000, 16'h0002, 32'h0, 2'd0);
    @(negedge clk);
    check("two_rdy", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'b0, out_valid}, 32'd0);
    check("arst_rdy",   {31'b0, in_ready},  32'd1);
    @(negedge clk);
    check("arst_valid2", {31'b0, out_valid}, 32'd0);
    check("arst_data",   out_data, 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_valid", {31'b0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ext_unit_pipe.md
Name: ext_unit_pipe

Overview:
- Registered, handshaked successor to the combinational immediate extender in the MIPS datapath.
- Given an opcode, it produces the DATA_W-bit operand for:
  - I-type ALU immediates (sign or zero extension);
  - LUI (immediate placed in the upper half);
  - sub-word loads (byte/halfword lane select, then sign or zero extension).
- It sits between decode/memory-return and the next pipeline stage.
- It has a 2-entry skid buffer so a stalled consumer never drops data and in_ready is a pure register output.

Parameters:
- DATA_W, 32: operand/word width. Must be a multiple of 16, ≥ 2*IMM_W.
- IMM_W, 16: immediate field width.
- OP_W, 6: opcode width.
- BOFF_W, $clog2(DATA_W/8): byte-offset width. Derived; must not be overridden.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream has an item.
- in_ready  out  1  unit can accept. Registered.
- in_op  in  OP_W  MIPS opcode.
- in_imm  in  IMM_W  immediate field.
- in_word  in  DATA_W  load data word. Ignored for non-load ops.
- in_boff  in  BOFF_W  byte offset of the load address.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  extended operand.
- out_misalign  out  1  halfword load at an odd offset.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values:
  - out_valid=0, out_data=0, out_misalign=0.
  - in_ready=1.
  - Both buffer entries invalid.
  - Asserting rst_n low mid-operation discards all held items immediately; no partial output.
- Handshake:
  - in fire = in_valid & in_ready.
  - out fire = out_valid & out_ready.
  - Once out_valid=1, out_data and out_misalign hold stable until out fire.
- Latency: an item accepted at edge N appears at out_valid after edge N when the main register is free (1 cycle). Throughput is 1/cycle while out_ready=1.
- Mode decode (combinational, on in_op):
  - 001100, 001101, 001110 (andi/ori/xori): ZERO. out = zero-extend(in_imm).
  - 001111 (lui): UPPER. out[2*IMM_W-1:IMM_W] = in_imm; all other bits 0.
  - 100000 (lb): lane k = in_boff; out = sign-extend(in_word[8k+7:8k]).
  - 100100 (lbu): same lane as lb; zero-extended.
  - 100001 (lh): halfword h = in_boff[BOFF_W-1:1]; out = sign-extend(in_word[16h+15:16h]).
  - 100101 (lhu): same halfword as lh; zero-extended.
  - 100011 (lw): out = in_word unchanged.
  - Anything else: SIGN. out = sign-extend(in_imm).
- Lanes are little-endian: byte 0 = in_word[7:0].
- Misalignment: for lh/lhu with in_boff[0]=1, out_misalign=1 and out_data=0. For all other cases out_misalign=0. Byte loads are never misaligned.
- Buffer FSM, states EMPTY / ONE / TWO. Main register drives the outputs; the skid register holds overflow.
  - EMPTY: in fire → ONE (main loaded).
  - ONE:
    - in fire & !out fire → TWO (skid loaded).
    - in fire & out fire → ONE (main reloaded).
    - out fire only → EMPTY.
  - TWO:
    - out fire → ONE (skid moves to main).
    - in fire is impossible because in_ready=0.
  - in_ready next = (next_state != TWO).
- Ordering: strict FIFO. No item is reordered or duplicated.

Decomposition:
- Package ext_pkg holds:
  - opcode localparams (OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW);
  - ext_mode_t enum: SIGN, ZERO, UPPER, LDB_S, LDB_U, LDH_S, LDH_U, LDW;
  - buffer state enum: EMPTY, ONE, TWO.
- Sub-module ext_core: purely combinational decode/extend plus the misalign flag. It is instantiated once, ahead of the buffer.
- ext_unit_pipe owns the skid FSM and registers.

Test Plan:
1. Reset with rst_n=0, then release → out_valid=0, in_ready=1, out_data=0. Reassert reset while in TWO → next cycle out_valid=0, in_ready=1.
2. out_ready=1, items streamed back to back:
   - addi imm=0x8001 → 0xFFFF8001;
   - ori imm=0x8001 → 0x00008001;
   - lui imm=0x1234 → 0x12340000.
   Each appears 1 cycle after acceptance, with no bubbles.
3. in_word=0x80FF7F01:
   - lb boff=2 → 0xFFFFFFFF;
   - lbu boff=3 → 0x00000080;
   - lh boff=2 → 0xFFFF80FF;
   - lhu boff=0 → 0x00007F01;
   - lw → 0x80FF7F01.
4. lh with boff=1 → out_misalign=1, out_data=0. The next lhu with boff=2 has out_misalign=0.
5. Stall: out_ready=0, three items presented (A, B, C):
   - in_ready drops after 2 accepts;
   - out_data holds A stable;
   - raising out_ready delivers A, B, C in order;
   - in_ready is back to 1 one cycle after A's out fire.
6. State ONE with in fire and out fire in the same cycle → out_data updates to the new item, state stays ONE, no loss.
